// File: rtl/ps2_device_port.sv
// ps2_device_port: keyboard-side end of a PS/2 link.
// Generates the PS/2 clock, sends device-to-host frames from a byte
// handshake, and receives host-to-device command frames with acknowledge.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   tx_data/tx_valid    byte to send; accepted when tx_valid & tx_ready
//   tx_ready            no byte pending and port idle
//   rx_data             last good command byte from the host (held)
//   rx_valid/rx_error   one-cycle pulses: good frame / bad parity or stop
//   busy                port is in any state other than IDLE
//   ps2_clk_in/out      clock line level / 1 pulls the clock line low
//   ps2_dat_in/out      data line level / 1 pulls the data line low
module ps2_device_port #(
    parameter int unsigned clkf     = 50000000,
    parameter int unsigned ps2_freq = 12500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    output logic       ps2_clk_out,
    input  logic       ps2_dat_in,
    output logic       ps2_dat_out
);

    // Half period of the PS/2 clock in system cycles.
    localparam int unsigned H  = clkf / (2 * ps2_freq);
    localparam int unsigned CW = $clog2(2 * H + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
    localparam logic [CW-1:0] HALF_LEN  = CW'(H);
    localparam logic [CW-1:0] IDLE_MIN  = CW'(2 * H);
    localparam logic [CW-1:0] SAMPLE_AT = CW'(H / 2);
    // Skips the port's own just-released clock low seen through the synchronizer.
    localparam logic [CW-1:0] GUARD     = CW'(4);

    typedef enum logic [2:0] {
        IDLE,
        TX_WAIT,
        TX_BIT,
        RX_WAIT,
        RX_BIT,
        RX_ACK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic          low_phase_q, low_phase_d;
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic [CW-1:0] low_cnt_q, low_cnt_d;
    logic          pend_q, pend_d;
    logic [7:0]    pend_data_q, pend_data_d;
    logic [8:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_error_q, rx_error_d;
    logic          tx_ready_q, tx_ready_d;
    logic          busy_q, busy_d;
    logic          clk_out_q, clk_out_d;
    logic          dat_out_q, dat_out_d;
    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;

    logic          clk_s;
    logic          dat_s;
    logic [10:0]   tx_frame_c;
    logic [3:0]    bit_nx_c;
    logic [9:0]    rx_full_c;

    assign clk_s      = clk_sync_q[1];
    assign dat_s      = dat_sync_q[1];
    // Frame bits in send order: start, d0..d7, odd parity, stop.
    assign tx_frame_c = {1'b1, ~^pend_data_q, pend_data_q, 1'b0};
    assign bit_nx_c   = bit_q + 4'd1;
    // d0..d7 and parity from the shift register, stop straight from the line.
    assign rx_full_c  = {dat_s, rx_shift_q};

    // Two-flop synchronizers for the asynchronous line levels; lines idle high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            low_phase_q <= 1'b0;
            idle_cnt_q  <= '0;
            low_cnt_q   <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_error_q  <= 1'b0;
            tx_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            clk_out_q   <= 1'b0;
            dat_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            low_phase_q <= low_phase_d;
            idle_cnt_q  <= idle_cnt_d;
            low_cnt_q   <= low_cnt_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_error_q  <= rx_error_d;
            tx_ready_q  <= tx_ready_d;
            busy_q      <= busy_d;
            clk_out_q   <= clk_out_d;
            dat_out_q   <= dat_out_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        bit_d       = bit_q;
        low_phase_d = low_phase_q;
        idle_cnt_d  = '0;
        low_cnt_d   = '0;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_error_d  = 1'b0;
        clk_out_d   = clk_out_q;
        dat_out_d   = dat_out_q;

        if (tx_valid && tx_ready_q) begin
            pend_d      = 1'b1;
            pend_data_d = tx_data;
        end

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                dat_out_d = 1'b0;
                if (clk_s && dat_s) begin
                    idle_cnt_d = (idle_cnt_q >= IDLE_MIN) ? idle_cnt_q : idle_cnt_q + CW'(1);
                end
                if (!clk_s) begin
                    low_cnt_d = (low_cnt_q >= HALF_LEN) ? low_cnt_q : low_cnt_q + CW'(1);
                end
                // Request-to-send: clock held low long enough, released with data low.
                if (low_cnt_q >= HALF_LEN && clk_s && !dat_s) begin
                    state_d = RX_WAIT;
                end else if (pend_q && idle_cnt_q >= IDLE_MIN) begin
                    state_d     = TX_BIT;
                    bit_d       = 4'd0;
                    low_phase_d = 1'b0;
                    dat_out_d   = ~tx_frame_c[0];
                end
            end

            TX_BIT: begin
                if (!low_phase_q) begin
                    if (bit_q <= 4'd9 && cnt_q >= GUARD && !clk_s) begin
                        // Host inhibit: drop the frame, keep the byte for a retry.
                        state_d   = IDLE;
                        cnt_d     = '0;
                        clk_out_d = 1'b0;
                        dat_out_d = 1'b0;
                    end else if (cnt_q == HALF_LAST) begin
                        cnt_d       = '0;
                        low_phase_d = 1'b1;
                        clk_out_d   = 1'b1;
                    end
                end else if (cnt_q == HALF_LAST) begin
                    cnt_d       = '0;
                    low_phase_d = 1'b0;
                    clk_out_d   = 1'b0;
                    if (bit_q == 4'd10) begin
                        state_d   = TX_WAIT;
                        dat_out_d = 1'b0;
                    end else begin
                        bit_d     = bit_nx_c;
                        dat_out_d = ~tx_frame_c[bit_nx_c];
                    end
                end
            end

            // Trailing high phase after the stop bit; frame counts as delivered.
            TX_WAIT: begin
                clk_out_d = 1'b0;
                dat_out_d = 1'b0;
                if (cnt_q == HALF_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            end

            RX_WAIT: begin
                if (cnt_q == HALF_LAST) begin
                    state_d     = RX_BIT;
                    cnt_d       = '0;
                    bit_d       = 4'd0;
                    low_phase_d = 1'b1;
                    clk_out_d   = 1'b1;
                end
            end

            RX_BIT: begin
                if (low_phase_q) begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_d       = '0;
                        low_phase_d = 1'b0;
                        clk_out_d   = 1'b0;
                    end
                end else if (cnt_q >= GUARD && !clk_s) begin
                    // Host abort: no status pulse.
                    state_d   = IDLE;
                    cnt_d     = '0;
                    clk_out_d = 1'b0;
                    dat_out_d = 1'b0;
                end else begin
                    if (cnt_q == SAMPLE_AT) begin
                        if (bit_q == 4'd9) begin
                            if ((^rx_full_c[8:0]) && rx_full_c[9]) begin
                                rx_data_d  = rx_full_c[7:0];
                                rx_valid_d = 1'b1;
                            end else begin
                                rx_error_d = 1'b1;
                            end
                        end else begin
                            rx_shift_d = {dat_s, rx_shift_q[8:1]};
                        end
                    end
                    if (cnt_q == HALF_LAST) begin
                        cnt_d       = '0;
                        low_phase_d = 1'b1;
                        clk_out_d   = 1'b1;
                        if (bit_q == 4'd9) begin
                            state_d   = RX_ACK;
                            dat_out_d = 1'b1;
                        end else begin
                            bit_d = bit_nx_c;
                        end
                    end
                end
            end

            // 11th pulse with data held low for both phases.
            RX_ACK: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (low_phase_q) begin
                        low_phase_d = 1'b0;
                        clk_out_d   = 1'b0;
                    end else begin
                        state_d   = IDLE;
                        dat_out_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                clk_out_d = 1'b0;
                dat_out_d = 1'b0;
            end
        endcase

        tx_ready_d = !pend_d && (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_error    = rx_error_q;
    assign busy        = busy_q;
    assign ps2_clk_out = clk_out_q;
    assign ps2_dat_out = dat_out_q;

endmodule

// File: tb/tb_ps2_device_port.sv
// Directed bench for ps2_device_port with a simple PS/2 host model on the
// wired-AND clock and data lines (H = 40 cycles).
module tb_ps2_device_port;

    localparam int unsigned H = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic       busy;
    logic       ps2_clk_out;
    logic       ps2_dat_out;
    logic       host_clk_low = 1'b0;
    logic       host_dat_low = 1'b0;
    logic       ps2_clk_line;
    logic       ps2_dat_line;

    assign ps2_clk_line = ~(ps2_clk_out | host_clk_low);
    assign ps2_dat_line = ~(ps2_dat_out | host_dat_low);

    always #5 clk = ~clk;

    ps2_device_port #(
        .clkf    (1000000),
        .ps2_freq(12500)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_error   (rx_error),
        .busy       (busy),
        .ps2_clk_in (ps2_clk_line),
        .ps2_clk_out(ps2_clk_out),
        .ps2_dat_in (ps2_dat_line),
        .ps2_dat_out(ps2_dat_out)
    );

    int   checks = 0;
    int   errors = 0;
    int   valid_cycles = 0;
    int   error_cycles = 0;
    logic cap_en = 1'b0;
    int   tx_n = 0;
    logic cap_arr [0:255];
    logic mon_prev = 1'b1;

    // Host-side monitor: status pulse counts and data sampled on falling clock edges.
    always @(negedge clk) begin
        if (rx_valid) valid_cycles++;
        if (rx_error) error_cycles++;
        if (cap_en && mon_prev && !ps2_clk_line) begin
            if (tx_n < 256) cap_arr[tx_n] = ps2_dat_line;
            tx_n++;
        end
        mon_prev = ps2_clk_line;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame_from(input int base);
        logic [10:0] f;
        for (int i = 0; i < 11; i++) f[i] = cap_arr[base + i];
        return f;
    endfunction

    task automatic wait_fall(input int limit, output logic ok);
        logic prev;
        ok   = 1'b0;
        prev = ps2_clk_line;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (prev && !ps2_clk_line) begin
                ok = 1'b1;
                break;
            end
            prev = ps2_clk_line;
        end
    endtask

    task automatic wait_busy(input logic level, input int limit, output int n);
        n = 0;
        while (busy !== level && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_ready(input int limit, output int n);
        n = 0;
        while (tx_ready !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Host request-to-send then one command frame; optional byte handshake while clock is held.
    task automatic host_send(input logic [7:0] d, input logic par, input logic inject,
                             input logic [7:0] inj_d, input string tag);
        logic [9:0] bits;
        logic       ok;
        int         n;
        bits         = {1'b1, par, d};
        host_clk_low = 1'b1;
        repeat (10) @(negedge clk);
        if (inject) begin
            send_byte(inj_d);
            check({tag, "_inject_ready_low"}, 32'(tx_ready), 32'd0);
        end
        repeat (H + 20) @(negedge clk);
        host_dat_low = 1'b1;
        repeat (5) @(negedge clk);
        host_clk_low = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wait_fall(4 * H, ok);
            if (!ok) begin
                check({tag, "_pulse_timeout"}, 32'(ok), 32'd1);
                break;
            end
            host_dat_low = ~bits[i];
        end
        wait_fall(4 * H, ok);
        check({tag, "_ack_pulse_seen"}, 32'(ok), 32'd1);
        host_dat_low = 1'b0;
        repeat (H / 2) @(negedge clk);
        check({tag, "_ack_low_phase"}, 32'(ps2_dat_line), 32'd0);
        repeat (H) @(negedge clk);
        check({tag, "_ack_high_phase"}, 32'(ps2_dat_line), 32'd0);
        wait_busy(1'b0, 4 * H, n);
        check({tag, "_back_to_idle"}, 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int       n;
        int       base;
        int       v0;
        int       e0;
        logic     ok;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_clk_out", 32'(ps2_clk_out), 32'd0);
        check("rst_dat_out", 32'(ps2_dat_out), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_error", 32'(rx_error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("tx_ready_after_reset", 32'(tx_ready), 32'd1);

        // TX 0x1C: frame 0,00111000,0,1 and 23H latency to tx_ready.
        repeat (100) @(negedge clk);
        cap_en = 1'b1;
        base   = tx_n;
        send_byte(8'h1C);
        check("tx1c_ready_drop", 32'(tx_ready), 32'd0);
        wait_busy(1'b1, 500, n);
        check("tx1c_start", 32'(busy), 32'd1);
        wait_ready(2000, n);
        check("tx1c_duration", 32'(n), 32'd920);
        check("tx1c_bit_count", 32'(tx_n - base), 32'd11);
        check("tx1c_frame", 32'(frame_from(base)), 32'h438);
        check("tx1c_clk_released", 32'(ps2_clk_out), 32'd0);
        check("tx1c_dat_released", 32'(ps2_dat_out), 32'd0);

        // RX 0xED with good parity.
        cap_en = 1'b0;
        repeat (50) @(negedge clk);
        v0 = valid_cycles;
        e0 = error_cycles;
        host_send(8'hED, 1'b1, 1'b0, 8'h00, "rx_ed");
        check("rx_ed_valid_once", 32'(valid_cycles - v0), 32'd1);
        check("rx_ed_no_error", 32'(error_cycles - e0), 32'd0);
        check("rx_ed_data", 32'(rx_data), 32'hED);

        // RX 0x3C with bad parity: error pulse, data held.
        repeat (50) @(negedge clk);
        v0 = valid_cycles;
        e0 = error_cycles;
        host_send(8'h3C, 1'b0, 1'b0, 8'h00, "rx_bad");
        check("rx_bad_error_once", 32'(error_cycles - e0), 32'd1);
        check("rx_bad_no_valid", 32'(valid_cycles - v0), 32'd0);
        check("rx_bad_data_held", 32'(rx_data), 32'hED);

        // TX 0xAA inhibited in the bit-4 high phase, then retransmitted.
        repeat (150) @(negedge clk);
        cap_en = 1'b1;
        send_byte(8'hAA);
        wait_busy(1'b1, 500, n);
        check("txaa_start", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            wait_fall(4 * H, ok);
            if (!ok) begin
                check("txaa_fall_timeout", 32'(ok), 32'd1);
                break;
            end
        end
        repeat (H + 10) @(negedge clk);
        host_clk_low = 1'b1;
        repeat (2) @(negedge clk);
        check("txaa_inhibit_sync_delay", 32'(busy), 32'd1);
        @(negedge clk);
        check("txaa_inhibit_busy", 32'(busy), 32'd0);
        check("txaa_inhibit_clk_rel", 32'(ps2_clk_out), 32'd0);
        check("txaa_inhibit_dat_rel", 32'(ps2_dat_out), 32'd0);
        check("txaa_inhibit_ready_low", 32'(tx_ready), 32'd0);
        repeat (57) @(negedge clk);
        base         = tx_n;
        host_clk_low = 1'b0;
        wait_busy(1'b1, 500, n);
        check("txaa_retry_gap", 32'(n >= 81 && n <= 86), 32'd1);
        wait_ready(2000, n);
        check("txaa_retry_count", 32'(tx_n - base), 32'd11);
        check("txaa_retry_frame", 32'(frame_from(base)), 32'h754);

        // Host request wins over a pending byte; TX of 0x55 follows RX of 0x01.
        cap_en = 1'b0;
        repeat (50) @(negedge clk);
        v0 = valid_cycles;
        host_send(8'h01, 1'b0, 1'b1, 8'h55, "rts_pend");
        check("rts_pend_rx_valid", 32'(valid_cycles - v0), 32'd1);
        check("rts_pend_rx_data", 32'(rx_data), 32'h01);
        check("rts_pend_still_pending", 32'(tx_ready), 32'd0);
        cap_en = 1'b1;
        base   = tx_n;
        wait_busy(1'b1, 500, n);
        check("rts_pend_tx_start", 32'(busy), 32'd1);
        wait_ready(2000, n);
        check("rts_pend_tx_count", 32'(tx_n - base), 32'd11);
        check("rts_pend_tx_frame", 32'(frame_from(base)), 32'h6AA);

        // Reset in the middle of a TX frame.
        repeat (50) @(negedge clk);
        send_byte(8'h0F);
        wait_busy(1'b1, 500, n);
        wait_fall(4 * H, ok);
        wait_fall(4 * H, ok);
        repeat (5) @(negedge clk);
        check("midrst_clk_pulled", 32'(ps2_clk_out), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_clk_out", 32'(ps2_clk_out), 32'd0);
        check("midrst_dat_out", 32'(ps2_dat_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_tx_ready", 32'(tx_ready), 32'd1);
        base = tx_n;
        repeat (300) @(negedge clk);
        check("midrst_no_frame", 32'(tx_n - base), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
